// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared constants for the Fibonacci job sequencer
package fib_pkg;

    localparam int FIB_WIDTH = 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

endpackage

// File: rtl/fib_watchdog.sv
// rtl/fib_watchdog.sv - saturating job watchdog with clear/enable/expire
module fib_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    logic [15:0] count;

    // Stops at LAST so a stalled FSM can never see the counter wrap back to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 16'd1;
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/fib_job_sequencer.sv
// rtl/fib_job_sequencer.sv - request/response front-end that launches the Fibonacci core
module fib_job_sequencer
    import fib_pkg::*;
#(
    parameter int WIDTH   = FIB_WIDTH,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset_button,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a0,
    output logic [WIDTH-1:0] a0_init,
    output logic             core_restart,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_v0,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_v0,
    output logic             rsp_timeout,
    output logic             busy
);

    logic [1:0] state;
    logic       armed;
    logic       wd_expire;
    logic       done_ok;

    // A done level still high from the previous job only counts after it has been seen low.
    assign done_ok = armed && core_done;

    fib_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (reset_button),
        .clear  (state == S_LAUNCH),
        .enable ((state == S_RUN) && !done_ok && !wd_expire),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge reset_button) begin
        if (!reset_button) begin
            state       <= S_IDLE;
            a0_init     <= '0;
            rsp_v0      <= '0;
            rsp_timeout <= 1'b0;
            armed       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        a0_init <= req_a0;
                        if (req_a0 == '0) begin
                            rsp_v0      <= '0;
                            rsp_timeout <= 1'b0;
                            state       <= S_HOLD;
                        end else begin
                            state <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    armed <= 1'b0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (!core_done) begin
                        armed <= 1'b1;
                    end
                    if (done_ok) begin
                        rsp_v0      <= core_v0;
                        rsp_timeout <= 1'b0;
                        state       <= S_HOLD;
                    end else if (wd_expire) begin
                        rsp_v0      <= '0;
                        rsp_timeout <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready    = (state == S_IDLE);
    assign core_restart = (state == S_LAUNCH);
    assign rsp_valid    = (state == S_HOLD);
    assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_fib_job_sequencer.sv
// tb/tb_fib_job_sequencer.sv - directed bench with a behavioural Fibonacci core model
module tb_fib_job_sequencer;

    logic       clk = 1'b0;
    logic       reset_button = 1'b0;

    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_a0 = 8'd0;
    logic [7:0] a0_init;
    logic       core_restart;
    logic       core_done;
    logic [7:0] core_v0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_v0;
    logic       rsp_timeout;
    logic       busy;

    logic       wd_req_valid = 1'b0;
    logic       wd_req_ready;
    logic [7:0] wd_req_a0 = 8'd0;
    logic [7:0] wd_a0_init;
    logic       wd_core_restart;
    logic       wd_core_done = 1'b0;
    logic [7:0] wd_core_v0 = 8'hAA;
    logic       wd_rsp_valid;
    logic       wd_rsp_ready = 1'b0;
    logic [7:0] wd_rsp_v0;
    logic       wd_rsp_timeout;
    logic       wd_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int restart_cnt = 0;

    always #5 clk = ~clk;

    fib_job_sequencer #(.WIDTH(8), .TIMEOUT(255)) dut (
        .clk          (clk),
        .reset_button (reset_button),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a0       (req_a0),
        .a0_init      (a0_init),
        .core_restart (core_restart),
        .core_done    (core_done),
        .core_v0      (core_v0),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_v0       (rsp_v0),
        .rsp_timeout  (rsp_timeout),
        .busy         (busy)
    );

    fib_job_sequencer #(.WIDTH(8), .TIMEOUT(16)) dut_wd (
        .clk          (clk),
        .reset_button (reset_button),
        .req_valid    (wd_req_valid),
        .req_ready    (wd_req_ready),
        .req_a0       (wd_req_a0),
        .a0_init      (wd_a0_init),
        .core_restart (wd_core_restart),
        .core_done    (wd_core_done),
        .core_v0      (wd_core_v0),
        .rsp_valid    (wd_rsp_valid),
        .rsp_ready    (wd_rsp_ready),
        .rsp_v0       (wd_rsp_v0),
        .rsp_timeout  (wd_rsp_timeout),
        .busy         (wd_busy)
    );

    function automatic logic [7:0] fib_f(input logic [7:0] n);
        logic [7:0] a = 8'd0;
        logic [7:0] b = 8'd1;
        logic [7:0] t;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Core model: done after 2*a0+3 cycles; optionally keeps the previous done/v0 for stale_hold cycles.
    int         t_m = 0;
    logic       run_m = 1'b0;
    logic [7:0] a_m = 8'd0;
    logic [7:0] old_v0 = 8'd0;
    int         stale_hold = 0;

    always @(posedge clk) begin
        if (core_restart) begin
            t_m    <= 0;
            run_m  <= 1'b1;
            a_m    <= a0_init;
            old_v0 <= fib_f(a_m);
            restart_cnt <= restart_cnt + 1;
        end else if (run_m && t_m < 100000) begin
            t_m <= t_m + 1;
        end
    end

    assign core_done = run_m && ((t_m < stale_hold) || (t_m >= stale_hold + 2 * int'(a_m) + 3));
    assign core_v0   = (t_m < stale_hold) ? old_v0 : fib_f(a_m);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one cycle after the accepting edge.
    task automatic do_req(input logic [7:0] a0);
        int n = 0;
        req_a0    = a0;
        req_valid = 1'b1;
        while (!req_ready && n < 100) begin
            step();
            n++;
        end
        check("req_ready_seen", {31'd0, req_ready}, 1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [7:0] exp_a0);
        int   n = 0;
        logic a0_ok = 1'b1;
        while (!rsp_valid && n < 600) begin
            if (a0_init !== exp_a0) a0_ok = 1'b0;
            step();
            n++;
        end
        check({tag, "_rsp_seen"}, {31'd0, rsp_valid}, 1);
        check({tag, "_a0_stable"}, {31'd0, a0_ok}, 1);
    endtask

    initial begin
        int   n;
        int   n_run;
        int   rc;
        logic bad;

        // reset state
        step();
        step();
        check("rst_state_busy", {31'd0, busy}, 0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        check("rst_a0_init", {24'd0, a0_init}, 0);
        check("rst_core_restart", {31'd0, core_restart}, 0);
        check("rst_rsp_v0", {24'd0, rsp_v0}, 0);
        check("rst_rsp_timeout", {31'd0, rsp_timeout}, 0);
        reset_button = 1'b1;
        step();
        check("idle_req_ready", {31'd0, req_ready}, 1);

        // 1: a0=7 -> 13
        rsp_ready = 1'b1;
        rc = restart_cnt;
        do_req(8'd7);
        check("t1_restart_T1", {31'd0, core_restart}, 1);
        check("t1_a0_init", {24'd0, a0_init}, 7);
        step();
        check("t1_restart_T2", {31'd0, core_restart}, 0);
        check("t1_busy_run", {31'd0, busy}, 1);
        wait_rsp("t1", 8'd7);
        check("t1_rsp_v0", {24'd0, rsp_v0}, 13);
        check("t1_rsp_timeout", {31'd0, rsp_timeout}, 0);
        step();
        check("t1_rsp_valid_drop", {31'd0, rsp_valid}, 0);
        check("t1_busy_drop", {31'd0, busy}, 0);
        check("t1_restart_count", restart_cnt - rc, 1);

        // 2: a0=0 bypasses the core
        rsp_ready = 1'b0;
        rc = restart_cnt;
        do_req(8'd0);
        check("t2_rsp_valid_T1", {31'd0, rsp_valid}, 1);
        check("t2_restart", {31'd0, core_restart}, 0);
        check("t2_rsp_v0", {24'd0, rsp_v0}, 0);
        check("t2_rsp_timeout", {31'd0, rsp_timeout}, 0);
        rsp_ready = 1'b1;
        step();
        check("t2_rsp_valid_drop", {31'd0, rsp_valid}, 0);
        check("t2_restart_count", restart_cnt - rc, 0);

        // 3: stale done from job 1 (v0=13) must be ignored
        stale_hold = 3;
        do_req(8'd5);
        wait_rsp("t3", 8'd5);
        check("t3_rsp_v0", {24'd0, rsp_v0}, 5);
        check("t3_rsp_timeout", {31'd0, rsp_timeout}, 0);
        step();
        stale_hold = 0;

        // 4: core never finishes, TIMEOUT=16
        wd_req_a0    = 8'd9;
        wd_req_valid = 1'b1;
        step();
        wd_req_valid = 1'b0;
        check("t4_restart", {31'd0, wd_core_restart}, 1);
        step();
        n_run = 0;
        n = 0;
        while (!wd_rsp_valid && n < 100) begin
            if (wd_busy && !wd_core_restart) n_run++;
            step();
            n++;
        end
        check("t4_rsp_seen", {31'd0, wd_rsp_valid}, 1);
        check("t4_run_cycles", n_run, 16);
        check("t4_rsp_timeout", {31'd0, wd_rsp_timeout}, 1);
        check("t4_rsp_v0", {24'd0, wd_rsp_v0}, 0);
        check("t4_a0_init", {24'd0, wd_a0_init}, 9);
        wd_rsp_ready = 1'b1;
        step();
        check("t4_busy_drop", {31'd0, wd_busy}, 0);

        // 5: back-pressure with a second request held
        rsp_ready = 1'b0;
        do_req(8'd4);
        req_a0    = 8'd6;
        req_valid = 1'b1;
        wait_rsp("t5", 8'd4);
        rc = restart_cnt;
        for (int i = 0; i < 10; i++) begin
            check("t5_hold_v0", {24'd0, rsp_v0}, 3);
            check("t5_hold_valid", {31'd0, rsp_valid}, 1);
            check("t5_hold_req_ready", {31'd0, req_ready}, 0);
            check("t5_hold_a0", {24'd0, a0_init}, 4);
            step();
        end
        check("t5_no_restart", restart_cnt - rc, 0);
        rsp_ready = 1'b1;
        step();
        check("t5_after_hs_valid", {31'd0, rsp_valid}, 0);
        check("t5_after_hs_a0", {24'd0, a0_init}, 4);
        check("t5_after_hs_ready", {31'd0, req_ready}, 1);
        step();
        req_valid = 1'b0;
        check("t5_second_a0", {24'd0, a0_init}, 6);
        check("t5_second_restart", {31'd0, core_restart}, 1);
        wait_rsp("t5b", 8'd6);
        check("t5_second_v0", {24'd0, rsp_v0}, 8);
        step();

        // 6: asynchronous reset in RUN
        do_req(8'd7);
        step();
        step();
        check("t6_in_run", {31'd0, busy}, 1);
        #3;
        reset_button = 1'b0;
        #1;
        check("t6_async_busy", {31'd0, busy}, 0);
        check("t6_async_a0", {24'd0, a0_init}, 0);
        check("t6_async_valid", {31'd0, rsp_valid}, 0);
        step();
        reset_button = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid || busy) bad = 1'b1;
            step();
        end
        check("t6_no_response", {31'd0, bad}, 0);
        do_req(8'd3);
        wait_rsp("t6", 8'd3);
        check("t6_rsp_v0", {24'd0, rsp_v0}, 2);
        check("t6_rsp_timeout", {31'd0, rsp_timeout}, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
